// File: rtl/score_pkg.sv
// Shared types and BCD helpers for the score/timer engine.
// Holds the state encoding exposed on state_o plus small packed-BCD arithmetic functions.
package score_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_TALLY = 3'd2,
        ST_OVER  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [23:0] BCD_MAX_SCORE = 24'h999999;

    // One BCD digit add; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (s > 5'd9) begin
            return {1'b1, 4'(s - 5'd10)};
        end
        return s;
    endfunction

    function automatic logic [23:0] bcd_add_sat6_f(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        logic [4:0]  d;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d          = bcd_digit_add(a[i*4 +: 4], b[i*4 +: 4], c);
            r[i*4 +: 4] = d[3:0];
            c          = d[4];
        end
        return c ? BCD_MAX_SCORE : r;
    endfunction

    // Three-digit BCD decrement that stops at 000.
    function automatic logic [11:0] bcd_dec3(input logic [11:0] t);
        logic [11:0] r;
        logic        borrow;
        r      = t;
        borrow = (t != 12'h000);
        for (int i = 0; i < 3; i++) begin
            if (borrow) begin
                if (t[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid6(input logic [23:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/bcd_add_sat6.sv
// Combinational 6-digit packed-BCD adder that clamps at 999999 instead of wrapping.
module bcd_add_sat6
    import score_pkg::*;
(
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    output logic [23:0] o_sum
);
    assign o_sum = bcd_add_sat6_f(i_a, i_b);
endmodule

// File: rtl/score_timer.sv
// Score and countdown-timer engine: edge-detected game events in, packed-BCD score/time out.
// Define SCORE_TIME_BONUS_EN to build the end-of-level time bonus tally; otherwise win goes to DONE.
module score_timer
    import score_pkg::*;
#(
    parameter int          FRAMES_PER_SEC = 24,
    parameter logic [11:0] TIME_START     = 12'h400,
    parameter logic [23:0] STOMP_PTS      = 24'h000100,
    parameter logic [23:0] MUSH_PTS       = 24'h001000,
    parameter logic [23:0] BONUS_PTS      = 24'h000050,
    parameter int          TALLY_DIV      = 500000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        startScreen,
    input  logic        killGoomba,
    input  logic        collision,
    input  logic        win,
    input  logic        gameover,
    output logic [23:0] score_bcd,
    output logic [11:0] time_bcd,
    output logic        time_up,
    output logic [2:0]  state_o
);
    localparam logic [7:0]  FPS_LAST = 8'(FRAMES_PER_SEC - 1);
    localparam logic [23:0] BOTH_PTS = bcd_add_sat6_f(STOMP_PTS, MUSH_PTS);

    state_t      r_state, w_state_next;
    logic [23:0] r_score, w_score_next, w_addend, w_sum;
    logic [11:0] r_time, w_time_next, w_time_dec;
    logic        r_time_up, w_time_up_next;
    logic [7:0]  r_frame, w_frame_next;
    logic        r_fc_meta, r_fc_sync, r_fc_prev;
    logic        r_start_prev, r_kill_prev, r_coll_prev, r_win_prev, r_over_prev;
    logic        w_frame_rise, w_start_rise, w_start_fall;
    logic        w_stomp_rise, w_mush_rise, w_win_rise, w_over_rise;

    assign w_frame_rise = r_fc_sync & ~r_fc_prev;
    assign w_start_rise = startScreen & ~r_start_prev;
    assign w_start_fall = ~startScreen & r_start_prev;
    assign w_stomp_rise = killGoomba & ~r_kill_prev;
    assign w_mush_rise  = collision & ~r_coll_prev;
    assign w_win_rise   = win & ~r_win_prev;
    assign w_over_rise  = gameover & ~r_over_prev;
    assign w_time_dec   = bcd_dec3(r_time);

`ifdef SCORE_TIME_BONUS_EN
    localparam int             TW         = $clog2(TALLY_DIV);
    localparam logic [TW-1:0]  TALLY_LAST = TW'(TALLY_DIV - 1);
    localparam state_t         WIN_DEST   = ST_TALLY;
    logic [TW-1:0] r_tally, w_tally_next;
    logic          w_tally_tick;
    assign w_tally_tick = (r_tally == TALLY_LAST);
`else
    localparam state_t WIN_DEST = ST_DONE;
    logic w_unused_cfg;
    assign w_unused_cfg = ^{BONUS_PTS, TALLY_DIV};
`endif

    always_comb begin
        w_addend = '0;
        if (r_state == ST_RUN) begin
            case ({w_stomp_rise, w_mush_rise})
                2'b10:   w_addend = STOMP_PTS;
                2'b01:   w_addend = MUSH_PTS;
                2'b11:   w_addend = BOTH_PTS;
                default: w_addend = '0;
            endcase
        end
`ifdef SCORE_TIME_BONUS_EN
        else if (r_state == ST_TALLY && w_tally_tick && r_time != 12'h000) begin
            w_addend = BONUS_PTS;
        end
`endif
    end

    bcd_add_sat6 u_add (
        .i_a   (r_score),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    always_comb begin
        w_state_next   = r_state;
        w_score_next   = r_score;
        w_time_next    = r_time;
        w_time_up_next = 1'b0;
        w_frame_next   = r_frame;
`ifdef SCORE_TIME_BONUS_EN
        w_tally_next   = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_score_next = '0;
                w_time_next  = TIME_START;
                w_frame_next = '0;
                if (w_start_fall) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_score_next = w_sum;
                if (w_frame_rise) begin
                    if (r_frame == FPS_LAST) begin
                        w_frame_next = '0;
                        w_time_next  = w_time_dec;
                        // Expiry only counts when neither higher-priority event fires.
                        if (r_time == 12'h001 && !w_over_rise && !w_win_rise) begin
                            w_time_up_next = 1'b1;
                            w_state_next   = ST_OVER;
                        end
                    end else begin
                        w_frame_next = r_frame + 8'd1;
                    end
                end
                if (w_over_rise)     w_state_next = ST_OVER;
                else if (w_win_rise) w_state_next = WIN_DEST;
            end
`ifdef SCORE_TIME_BONUS_EN
            ST_TALLY: begin
                if (r_time == 12'h000) begin
                    w_state_next = ST_DONE;
                end else if (w_tally_tick) begin
                    w_time_next  = w_time_dec;
                    w_score_next = w_sum;
                end else begin
                    w_tally_next = r_tally + TW'(1);
                end
            end
`endif
            default: ;
        endcase
        if (w_start_rise) begin
            w_state_next   = ST_IDLE;
            w_score_next   = '0;
            w_time_next    = TIME_START;
            w_time_up_next = 1'b0;
            w_frame_next   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_score      <= '0;
            r_time       <= TIME_START;
            r_time_up    <= 1'b0;
            r_frame      <= '0;
            r_fc_meta    <= 1'b0;
            r_fc_sync    <= 1'b0;
            r_fc_prev    <= 1'b0;
            r_start_prev <= 1'b0;
            r_kill_prev  <= 1'b0;
            r_coll_prev  <= 1'b0;
            r_win_prev   <= 1'b0;
            r_over_prev  <= 1'b0;
`ifdef SCORE_TIME_BONUS_EN
            r_tally      <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_score      <= w_score_next;
            r_time       <= w_time_next;
            r_time_up    <= w_time_up_next;
            r_frame      <= w_frame_next;
            r_fc_meta    <= frame_clk;
            r_fc_sync    <= r_fc_meta;
            r_fc_prev    <= r_fc_sync;
            r_start_prev <= startScreen;
            r_kill_prev  <= killGoomba;
            r_coll_prev  <= collision;
            r_win_prev   <= win;
            r_over_prev  <= gameover;
`ifdef SCORE_TIME_BONUS_EN
            r_tally      <= w_tally_next;
`endif
        end
    end

    assign score_bcd = r_score;
    assign time_bcd  = r_time;
    assign time_up   = r_time_up;
    assign state_o   = r_state;

endmodule

// File: tb/tb_score_timer.sv
// Self-checking bench for score_timer: directed phases plus random events against a decimal model.
module tb_score_timer;
    localparam int FPS       = 2;
    localparam int START_SEC = 400;
    localparam int STOMP_V   = 100;
    localparam int MUSH_V    = 1000;
    localparam int BONUS_V   = 50;
    localparam int TDIV      = 4;
    localparam int MAXS      = 999999;
    localparam int S_IDLE = 0, S_RUN = 1, S_TALLY = 2, S_OVER = 3, S_DONE = 4;

    logic        Clk = 1'b0;
    logic        Reset_n, frame_clk, startScreen, killGoomba, collision, win, gameover;
    logic [23:0] score_bcd;
    logic [11:0] time_bcd;
    logic        time_up;
    logic [2:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int m_score, m_time, m_frames, m_state;
    int tu_count = 0;
    int tu0;
    logic [11:0] tu_last_time = 12'hfff;
    logic [11:0] prev_t;
    int steps[$];

    score_timer #(
        .FRAMES_PER_SEC (FPS),
        .TIME_START     (12'h400),
        .STOMP_PTS      (24'h000100),
        .MUSH_PTS       (24'h001000),
        .BONUS_PTS      (24'h000050),
        .TALLY_DIV      (TDIV)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .startScreen (startScreen),
        .killGoomba  (killGoomba),
        .collision   (collision),
        .win         (win),
        .gameover    (gameover),
        .score_bcd   (score_bcd),
        .time_bcd    (time_bcd),
        .time_up     (time_up),
        .state_o     (state_o)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (time_up === 1'b1) begin
            tu_count     <= tu_count + 1;
            tu_last_time <= time_bcd;
        end
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/score"}, score_bcd, to_bcd(m_score));
        check({tag, "/time"}, 24'(time_bcd), to_bcd(m_time));
        check({tag, "/state"}, 24'(state_o), 24'(m_state));
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; step(); step();
        frame_clk = 1'b0; step(); step();
        if (m_state == S_RUN) begin
            m_frames++;
            if (m_frames == FPS) begin
                m_frames = 0;
                if (m_time > 0) begin
                    m_time--;
                    if (m_time == 0) m_state = S_OVER;
                end
            end
        end
    endtask

    task automatic points(input bit k, input bit c);
        killGoomba = k; collision = c; step();
        killGoomba = 1'b0; collision = 1'b0; step();
        if (m_state == S_RUN) begin
            m_score = m_score + (k ? STOMP_V : 0) + (c ? MUSH_V : 0);
            if (m_score > MAXS) m_score = MAXS;
        end
    endtask

    task automatic restart();
        startScreen = 1'b1; step();
        m_state = S_IDLE; m_score = 0; m_time = START_SEC; m_frames = 0;
        check_all("abort_to_idle");
        startScreen = 1'b0; step();
        m_state = S_RUN;
        check_all("start_run");
    endtask

    initial begin
        Reset_n = 1'b0; startScreen = 1'b1; frame_clk = 1'b0;
        killGoomba = 1'b0; collision = 1'b0; win = 1'b0; gameover = 1'b0;
        repeat (3) step();
        m_state = S_IDLE; m_score = 0; m_time = START_SEC; m_frames = 0;
        check_all("reset");
        check("reset/time_up", 24'(time_up), 24'h0);
        Reset_n = 1'b1; step(); step();
        check_all("idle_hold");

        startScreen = 1'b0; step();
        m_state = S_RUN;
        check_all("run_entry");
        repeat (4) frame_pulse();
        check_all("frames4");
        check("frames4/abs", 24'(time_bcd), 24'h000398);

        killGoomba = 1'b1; collision = 1'b1;
        repeat (11) step();
        m_score = m_score + STOMP_V + MUSH_V;
        check_all("both_held");
        check("both_held/abs", score_bcd, 24'h001100);
        killGoomba = 1'b0; collision = 1'b0; step();

        for (int t = 0; t < 30; t++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0:       points(1'b1, 1'b0);
                1:       points(1'b0, 1'b1);
                2:       points(1'b1, 1'b1);
                default: frame_pulse();
            endcase
            repeat ($urandom_range(0, 2)) step();
            check_all("random");
            $display("[TB] txn %0d op %0d score %h time %h state %0d", t, op, score_bcd, time_bcd, state_o);
        end

        restart();
        repeat (999) points(1'b0, 1'b1);
        repeat (9) points(1'b1, 1'b0);
        check_all("preload");
        check("preload/abs", score_bcd, 24'h999900);
        points(1'b1, 1'b0);
        check_all("sat_stomp");
        check("sat_stomp/abs", score_bcd, 24'h999999);
        points(1'b1, 1'b1);
        check_all("sat_both");

        restart();
        tu0 = tu_count;
        for (int f = 0; f < 1000 && m_state == S_RUN; f++) frame_pulse();
        check_all("expire");
        check("expire/abs", 24'(time_bcd), 24'h000000);
        check("expire/pulses", 24'(tu_count - tu0), 24'd1);
        check("expire/pulse_time", 24'(tu_last_time), 24'h000000);
        check("expire/time_up_low", 24'(time_up), 24'h0);
        repeat (4) frame_pulse();
        points(1'b1, 1'b0);
        check_all("over_frozen");
        check("over_frozen/pulses", 24'(tu_count - tu0), 24'd1);

        restart();
        for (int f = 0; f < 1000 && m_time > 3; f++) frame_pulse();
        points(1'b1, 1'b0);
        points(1'b1, 1'b0);
        check_all("pre_win");
        win = 1'b1; step();
        win = 1'b0;
`ifdef SCORE_TIME_BONUS_EN
        m_state = S_TALLY;
        check_all("tally_entry");
        prev_t = time_bcd;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (time_bcd !== prev_t) begin
                steps.push_back(c);
                prev_t = time_bcd;
            end
        end
        m_score = m_score + 3 * BONUS_V;
        m_time  = 0;
        m_state = S_DONE;
        check_all("tally_done");
        check("tally/steps", 24'(steps.size()), 24'd3);
        if (steps.size() == 3) begin
            check("tally/gap1", 24'(steps[1] - steps[0]), 24'(TDIV));
            check("tally/gap2", 24'(steps[2] - steps[1]), 24'(TDIV));
        end
`else
        m_state = S_DONE;
        check_all("win_done");
        repeat (10) step();
        frame_pulse();
        points(1'b1, 1'b1);
        check_all("done_frozen");
`endif

        restart();
        frame_pulse();
        frame_pulse();
        win = 1'b1; gameover = 1'b1; step();
        m_state = S_OVER;
        check_all("over_beats_win");
        win = 1'b0; gameover = 1'b0; step();
        frame_pulse();
        points(1'b1, 1'b0);
        check_all("over_frozen2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
